// File: rtl/data_array_port_arbiter.sv
// Single-RW-port owner for a 2048x64 data-array macro: zero-fills every row after reset,
// then arbitrates refill (A, high priority) and core (B) with an anti-starvation override.
module data_array_port_arbiter #(
  parameter int unsigned ADDR_W       = 11,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic [1:0]        a_wmask,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_write,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic [1:0]        b_wmask,
  output logic              b_resp_valid,
  output logic [DATA_W-1:0] b_resp_data,
  output logic              init_done,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic [1:0]        sram_wmask,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  localparam logic [3:0]        Limit   = 4'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] LastRow = '1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   init_ptr_q, init_ptr_d;
  logic [3:0]          starve_q, starve_d;
  logic                rd_pend_q, rd_pend_d;
  logic [DATA_W-1:0]   resp_data_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [1:0]          wmask_q;
  logic                grant_a, grant_b;

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    starve_d   = starve_q;
    rd_pend_d  = 1'b0;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = addr_q;
    sram_wdata = wdata_q;
    sram_wmask = wmask_q;
    case (state_q)
      StInit: begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_addr  = init_ptr_q;
        sram_wdata = '0;
        sram_wmask = 2'b11;
        init_ptr_d = init_ptr_q + 1'b1;
        starve_d   = '0;
        if (init_ptr_q == LastRow) state_d = StRun;
      end
      StRun: begin
        grant_b = b_valid && (!a_valid || (starve_q == Limit));
        grant_a = a_valid && !grant_b;
        if (grant_a) begin
          sram_en    = 1'b1;
          sram_wmode = 1'b1;
          sram_addr  = a_addr;
          sram_wdata = a_wdata;
          sram_wmask = a_wmask;
        end else if (grant_b) begin
          sram_en    = 1'b1;
          sram_wmode = b_write;
          sram_addr  = b_addr;
          sram_wdata = b_wdata;
          sram_wmask = b_write ? b_wmask : 2'b00;
        end
        if (!b_valid || grant_b) begin
          starve_d = '0;
        end else if (starve_q != Limit) begin
          starve_d = starve_q + 4'd1;
        end
        rd_pend_d = grant_b && !b_write;
      end
      default: state_d = StInit;
    endcase
    // Keep the macro quiet while reset is held, even though the FSM already sits in StInit.
    if (!reset_n) begin
      grant_a    = 1'b0;
      grant_b    = 1'b0;
      sram_en    = 1'b0;
      sram_wmode = 1'b0;
      sram_addr  = '0;
      sram_wdata = '0;
      sram_wmask = 2'b00;
    end
  end

  assign a_ready      = grant_a;
  assign b_ready      = grant_b;
  assign init_done    = (state_q == StRun);
  assign b_resp_valid = rd_pend_q;
  assign b_resp_data  = rd_pend_q ? sram_rdata : resp_data_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StInit;
      init_ptr_q  <= '0;
      starve_q    <= '0;
      rd_pend_q   <= 1'b0;
      resp_data_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      init_ptr_q  <= init_ptr_d;
      starve_q    <= starve_d;
      rd_pend_q   <= rd_pend_d;
      resp_data_q <= b_resp_data;
      addr_q      <= sram_addr;
      wdata_q     <= sram_wdata;
      wmask_q     <= sram_wmask;
    end
  end

endmodule
